// File: rtl/event_scoreboard.sv
// Event scoreboard: counts monitor events and mismatches over a run of
// i_num_checks events that starts MON_LATENCY cycles after i_start.
module event_scoreboard #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MON_LATENCY = 3,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [31:0]      i_num_checks,
  input  logic [WIDTH-1:0] i_event,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [31:0]      o_check_cnt,
  output logic [15:0]      o_err_cnt,
  output logic [31:0]      o_first_err_idx,
  output logic             o_err_seen
);

  localparam int unsigned LAT_W = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned ERR_W = 16;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic               seen_q, seen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  // Only bit 0 of the event word carries information.
  logic unused_event;
  assign unused_event = ^i_event[WIDTH-1:1];

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    lat_d   = lat_q;
    chk_d   = chk_q;
    err_d   = err_q;
    first_d = first_q;
    seen_d  = seen_q;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          num_d   = i_num_checks;
          lat_d   = LAT_W'(MON_LATENCY);
          chk_d   = '0;
          err_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (lat_q == '0) begin
          state_d = (num_q == '0) ? DONE : RUN;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RUN: begin
        chk_d = chk_q + CNT_W'(1);
        if (i_event[0]) begin
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          if (!seen_q) begin
            seen_d  = 1'b1;
            first_d = chk_q;
          end
        end
        if ((chk_d == num_q) || ((STOP_ON_ERR != 0) && i_event[0])) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ARM) || (state_d == RUN);
    done_d = (state_d == DONE) && (state_q != DONE);
    pass_d = (state_d == DONE) && (err_d == '0);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      lat_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      lat_q   <= lat_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_pass          = pass_q;
  assign o_check_cnt     = chk_q;
  assign o_err_cnt       = err_q;
  assign o_first_err_idx = first_q;
  assign o_err_seen      = seen_q;

endmodule
